// File: rtl/prbs8_pkg.sv
// Shared PRBS8 definitions: FSM states, feedback taps, LFSR step and popcount helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; reused by the matching generator so both ends agree on the polynomial.
package prbs8_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  // Fibonacci step: shift left, feedback of the tapped bits enters at bit 0.
  function automatic logic [7:0] prbs8_step(input logic [7:0] s);
    return {s[6:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/prbs8_sat_counter.sv
// Saturating event counter: adds a 0..15 increment, clamps at all-ones, synchronous clear.
// Latency: new count visible one cycle after clr/inc_en.
// Backpressure: none; clr wins over a coincident increment.
module prbs8_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [3:0]   inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W+3:0] sum;

  // Next count: clear first, otherwise widened add then clamp to all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sum   = {4'b0000, cnt_q} + {{W{1'b0}}, inc};
    if (clr) begin
      cnt_d = '0;
    end else if (inc_en) begin
      if (sum > {4'b0000, {W{1'b1}}}) begin
        cnt_d = '1;
      end else begin
        cnt_d = sum[W-1:0];
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/prbs8_checker.sv
// PRBS8 receive checker: self-seeds from the stream, locks after LOCK_CNT matches, flywheels and counts errors.
// Latency: all outputs registered, one cycle after the valid beat; in_valid=0 holds everything.
// Backpressure: none (always accepts). Define PRBS8_CHK_BITERR_EN to count bit errors instead of word errors.
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT    = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int CE_W = $clog2(UNLOCK_ERRS + 1);
  // Compare the pre-increment value so the "reaching" test needs no wider adder.
  localparam logic [MC_W-1:0] LOCK_LAST   = MC_W'(LOCK_CNT - 1);
  localparam logic [CE_W-1:0] UNLOCK_LAST = CE_W'(UNLOCK_ERRS - 1);

  state_t          state_q, state_d;
  logic [7:0]      expected_q, expected_d;
  logic [MC_W-1:0] match_cnt_q, match_cnt_d;
  logic [CE_W-1:0] consec_err_q, consec_err_d;
  logic            err_pulse_q, err_pulse_d;
  logic            mismatch;
  logic            cnt_en;
  logic [3:0]      err_inc;

  // Next-state: seeding, verify run, flywheel and unlock decisions.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    match_cnt_d  = match_cnt_q;
    consec_err_d = consec_err_q;
    err_pulse_d  = 1'b0;
    mismatch     = (in_data != expected_q);
    cnt_en       = in_valid && (state_q == LOCKED);
`ifdef PRBS8_CHK_BITERR_EN
    err_inc      = popcount8(in_data ^ expected_q);
`else
    err_inc      = {3'b000, mismatch};
`endif
    case (state_q)
      SEARCH: begin
        // All-zero is the LFSR lock-up state and can never be a valid seed.
        if (in_valid && (in_data != 8'h00)) begin
          expected_d  = prbs8_step(in_data);
          match_cnt_d = '0;
          state_d     = VERIFY;
        end
      end
      VERIFY: begin
        if (in_valid) begin
          if (!mismatch) begin
            match_cnt_d = match_cnt_q + MC_W'(1);
            expected_d  = prbs8_step(in_data);
            if (match_cnt_q == LOCK_LAST) begin
              state_d      = LOCKED;
              consec_err_d = '0;
            end
          end else if (in_data == 8'h00) begin
            match_cnt_d = '0;
            state_d     = SEARCH;
          end else begin
            expected_d  = prbs8_step(in_data);
            match_cnt_d = '0;
          end
        end
      end
      LOCKED: begin
        if (in_valid) begin
          // Flywheel: once locked, received data never reseeds the reference.
          expected_d = prbs8_step(expected_q);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (consec_err_q == UNLOCK_LAST) begin
              consec_err_d = '0;
              state_d      = SEARCH;
            end else begin
              consec_err_d = consec_err_q + CE_W'(1);
            end
          end else begin
            consec_err_d = '0;
          end
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      expected_q   <= 8'h00;
      match_cnt_q  <= '0;
      consec_err_q <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      match_cnt_q  <= match_cnt_d;
      consec_err_q <= consec_err_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;

  prbs8_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_cnt),
    .inc_en (cnt_en),
    .inc    (err_inc),
    .cnt    (err_cnt)
  );

  prbs8_sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr_cnt),
    .inc_en (cnt_en),
    .inc    (4'd1),
    .cnt    (word_cnt)
  );

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: two instances (default, and 4-bit counters with a high unlock threshold)
// share one stimulus stream and are checked every cycle against a run-length reference model,
// plus directed constant checks for lock, error, unlock, saturation, clear and reset scenarios.
module tb_prbs8_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr_cnt;

  logic        locked_a, err_pulse_a;
  logic [15:0] err_cnt_a, word_cnt_a;
  logic        locked_b, err_pulse_b;
  logic [3:0]  err_cnt_b, word_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

`ifdef PRBS8_CHK_BITERR_EN
  localparam bit BITERR = 1'b1;
`else
  localparam bit BITERR = 1'b0;
`endif

  always #5 clk = ~clk;

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_ERRS(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked_a), .err_pulse(err_pulse_a), .err_cnt(err_cnt_a), .word_cnt(word_cnt_a)
  );

  prbs8_checker #(.LOCK_CNT(4), .UNLOCK_ERRS(64), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
    .locked(locked_b), .err_pulse(err_pulse_b), .err_cnt(err_cnt_b), .word_cnt(word_cnt_b)
  );

  // Reference model state, one slot per instance.
  int          m_run    [2];
  logic [7:0]  m_prev   [2];
  logic [7:0]  m_exp    [2];
  bit          m_lock   [2];
  bit          m_pulse  [2];
  int          m_consec [2];
  longint      m_err    [2];
  longint      m_word   [2];
  int          m_unlock [2] = '{3, 64};
  longint      m_max    [2] = '{65535, 15};
  localparam int LOCKN = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Hunting is tracked as the length of the current run of nonzero, step-consistent words;
  // lock is declared once the run covers the seed plus LOCKN followers.
  task automatic model_step(input int i, input bit v, input logic [7:0] d, input bit c, input bit r);
    longint einc, winc;
    einc = 0;
    winc = 0;
    if (r) begin
      m_run[i] = 0; m_prev[i] = 8'h00; m_exp[i] = 8'h00; m_lock[i] = 0;
      m_pulse[i] = 0; m_consec[i] = 0; m_err[i] = 0; m_word[i] = 0;
      return;
    end
    m_pulse[i] = 0;
    if (v) begin
      if (m_lock[i]) begin
        winc = 1;
        if (d != m_exp[i]) begin
          einc = BITERR ? longint'($countones(d ^ m_exp[i])) : 1;
          m_pulse[i] = 1;
          m_consec[i]++;
          if (m_consec[i] == m_unlock[i]) begin
            m_lock[i] = 0; m_run[i] = 0; m_consec[i] = 0;
          end
        end else begin
          m_consec[i] = 0;
        end
        m_exp[i] = lfsr_next(m_exp[i]);
      end else begin
        if (m_run[i] > 0 && d == lfsr_next(m_prev[i])) m_run[i]++;
        else m_run[i] = (d != 8'h00) ? 1 : 0;
        m_prev[i] = d;
        if (m_run[i] == LOCKN + 1) begin
          m_lock[i] = 1; m_exp[i] = lfsr_next(d); m_consec[i] = 0;
        end
      end
    end
    if (c) begin
      m_err[i] = 0; m_word[i] = 0;
    end else begin
      m_err[i]  = (m_err[i] + einc > m_max[i]) ? m_max[i] : m_err[i] + einc;
      m_word[i] = (m_word[i] + winc > m_max[i]) ? m_max[i] : m_word[i] + winc;
    end
  endtask

  // One clock: drive at negedge, advance model after the edge, compare at the next negedge.
  task automatic drive_cycle(input bit v, input logic [7:0] d, input bit c, input bit r);
    in_valid = v; in_data = d; clr_cnt = c; rst = r;
    @(posedge clk);
    model_step(0, v, d, c, r);
    model_step(1, v, d, c, r);
    @(negedge clk);
    check_eq("a_locked",    32'(locked_a),    32'(m_lock[0]));
    check_eq("a_err_pulse", 32'(err_pulse_a), 32'(m_pulse[0]));
    check_eq("a_err_cnt",   32'(err_cnt_a),   32'(m_err[0]));
    check_eq("a_word_cnt",  32'(word_cnt_a),  32'(m_word[0]));
    check_eq("b_locked",    32'(locked_b),    32'(m_lock[1]));
    check_eq("b_err_pulse", 32'(err_pulse_b), 32'(m_pulse[1]));
    check_eq("b_err_cnt",   32'(err_cnt_b),   32'(m_err[1]));
    check_eq("b_word_cnt",  32'(word_cnt_b),  32'(m_word[1]));
  endtask

  task automatic send(input logic [7:0] d);
    drive_cycle(1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] g;
    logic [7:0] w;
    int sent;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0;
    @(negedge clk);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("rst_locked",  32'(locked_a),    32'd0);
    check_eq("rst_pulse",   32'(err_pulse_a), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt_a),   32'd0);
    check_eq("rst_word",    32'(word_cnt_a),  32'd0);

    // Zero word ignored in SEARCH; false start FF,FE then 55 reseeds.
    send(8'h00); send(8'h00);
    send(8'hFF); send(8'hFE); send(8'h55);
    check_eq("seed55_locked", 32'(locked_a), 32'd0);

    // Lock: FF seeds (mismatches step(55)=AB), then four matches.
    send(8'hFF); send(8'hFE); send(8'hFC); send(8'hF8);
    check_eq("lock_pre", 32'(locked_a), 32'd0);
    send(8'hF0);
    check_eq("lock_set",  32'(locked_a),   32'd1);
    check_eq("lock_err",  32'(err_cnt_a),  32'd0);
    check_eq("lock_word", 32'(word_cnt_a), 32'd0);

    // Single corrupted word E1->E2, then the flywheel continues at C2.
    send(8'hE2);
    check_eq("err_pulse",  32'(err_pulse_a), 32'd1);
    check_eq("err_cnt",    32'(err_cnt_a),   BITERR ? 32'd2 : 32'd1);
    check_eq("err_locked", 32'(locked_a),    32'd1);
    send(8'hC2);
    check_eq("err_next_pulse", 32'(err_pulse_a), 32'd0);
    check_eq("err_next_word",  32'(word_cnt_a),  32'd2);
    g = lfsr_next(8'hC2);
    for (int k = 0; k < 3; k++) begin send(g); g = lfsr_next(g); end

    // Three consecutive bad words drop lock on the default instance only.
    send(8'h00); send(8'h00);
    check_eq("unlock_hold", 32'(locked_a), 32'd1);
    send(8'h00);
    check_eq("unlock_a",    32'(locked_a), 32'd0);
    check_eq("unlock_b",    32'(locked_b), 32'd1);

    // Saturation on the 4-bit instance, then clear with a coincident error.
    for (int k = 0; k < 20; k++) send(8'h00);
    check_eq("sat_err",  32'(err_cnt_b),  32'hF);
    check_eq("sat_word", 32'(word_cnt_b), 32'hF);
    drive_cycle(1'b1, 8'h00, 1'b1, 1'b0);
    check_eq("clr_err",   32'(err_cnt_b),   32'd0);
    check_eq("clr_word",  32'(word_cnt_b),  32'd0);
    check_eq("clr_pulse", 32'(err_pulse_b), 32'd1);
    check_eq("clr_lock",  32'(locked_b),    32'd1);

    // Reset while locked.
    drive_cycle(1'b1, 8'h00, 1'b0, 1'b1);
    check_eq("midrst_locked", 32'(locked_b),    32'd0);
    check_eq("midrst_pulse",  32'(err_pulse_b), 32'd0);
    check_eq("midrst_err",    32'(err_cnt_b),   32'd0);

    // Full period with random gaps; idle cycles carry junk data that must be ignored.
    g = 8'($urandom_range(1, 255));
    sent = 0;
    while (sent < 300) begin
      if ($urandom_range(0, 3) != 0) begin send(g); g = lfsr_next(g); sent++; end
      else drive_cycle(1'b0, 8'($urandom), 1'b0, 1'b0);
    end
    check_eq("gap_locked", 32'(locked_a),  32'd1);
    check_eq("gap_err_a",  32'(err_cnt_a), 32'd0);
    check_eq("gap_err_b",  32'(err_cnt_b), 32'd0);

    // After reset, relock needs the seed plus four matches again.
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    w = 8'($urandom_range(1, 255));
    for (int k = 0; k < 4; k++) begin send(w); w = lfsr_next(w); end
    check_eq("relock_pre", 32'(locked_a), 32'd0);
    send(w); w = lfsr_next(w);
    check_eq("relock_set", 32'(locked_a), 32'd1);

    // Random traffic: gaps, corruptions, zero words, jumps, clears and occasional reset.
    for (int k = 0; k < 1500; k++) begin
      bit v, c, r;
      logic [7:0] d;
      int sel;
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 299) == 0);
      sel = $urandom_range(0, 99);
      if (sel < 5)       d = w ^ 8'($urandom_range(1, 255));
      else if (sel < 6)  d = 8'h00;
      else if (sel < 7)  begin w = 8'($urandom_range(1, 255)); d = w; end
      else               d = w;
      drive_cycle(v, v ? d : 8'($urandom), c, r);
      if (v) w = lfsr_next(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
